// File: rtl/field_counter.sv
// Two-digit decimal time field: counts MIN_VALUE..MAX_VALUE from an internal
// prescaler or a chained tick, with push-button adjust and blinking 7-segment output.
module field_counter #(
   parameter int MIN_VALUE = 0,
   parameter int MAX_VALUE = 59,
   parameter int W         = 7,
   parameter int EXT_TICK  = 0,
   parameter int TICK_DIV  = 50000000,
   parameter int BLINK_DIV = 12500000
) (
   input  logic         clk50,
   input  logic         reset,
   input  logic         disable_clk,
   input  logic         tick_in,
   input  logic         adj_n,
   input  logic         adj_up,
   output logic [W-1:0] value,
   output logic         carry_out,
   output logic [6:0]   led_tens,
   output logic [6:0]   led_ones
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [W-1:0]  V_MIN  = W'(MIN_VALUE);
   localparam logic [W-1:0]  V_MAX  = W'(MAX_VALUE);
   localparam logic [BW-1:0] B_TERM = BW'(BLINK_DIV - 1);

   logic          adj_s1, adj_s2, adj_d;
   logic          press;
   logic          tick;
   logic [BW-1:0] blink_cnt;
   logic          blank_phase;
   logic          blank;
   logic [7:0]    v8, tens8, ones8;

   // adj_n is asynchronous; the first two flops resynchronise, the third detects the falling edge
   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         adj_s1 <= 1'b1;
         adj_s2 <= 1'b1;
         adj_d  <= 1'b1;
      end else begin
         adj_s1 <= adj_n;
         adj_s2 <= adj_s1;
         adj_d  <= adj_s2;
      end
   end

   assign press = adj_d & ~adj_s2;

   generate
      if (EXT_TICK == 0) begin : g_int_tick
         localparam logic [TW-1:0] P_TERM = TW'(TICK_DIV - 1);
         logic [TW-1:0] presc;
         logic          unused_tick_in;

         assign unused_tick_in = tick_in;

         always_ff @(posedge clk50 or negedge reset) begin
            if (!reset) begin
               presc <= '0;
            end else if (press) begin
               presc <= '0;
            end else if (!disable_clk) begin
               presc <= (presc == P_TERM) ? '0 : presc + TW'(1);
            end
         end

         assign tick = ~disable_clk & (presc == P_TERM);
      end else begin : g_ext_tick
         assign tick = ~disable_clk & tick_in;
      end
   endgenerate

   // adjust wins over a coincident tick; that tick is dropped along with its carry
   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         value     <= V_MIN;
         carry_out <= 1'b0;
      end else begin
         carry_out <= 1'b0;
         if (press) begin
            if (adj_up)
               value <= (value == V_MAX) ? V_MIN : value + W'(1);
            else
               value <= (value == V_MIN) ? V_MAX : value - W'(1);
         end else if (tick) begin
            if (value == V_MAX) begin
               value     <= V_MIN;
               carry_out <= 1'b1;
            end else begin
               value <= value + W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         blink_cnt   <= '0;
         blank_phase <= 1'b0;
      end else if (!disable_clk) begin
         blink_cnt   <= '0;
         blank_phase <= 1'b0;
      end else if (blink_cnt == B_TERM) begin
         blink_cnt   <= '0;
         blank_phase <= ~blank_phase;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   function automatic logic [6:0] seg7(input logic [7:0] d);
      case (d)
         8'd0:    seg7 = 7'b1000000;
         8'd1:    seg7 = 7'b1111001;
         8'd2:    seg7 = 7'b0100100;
         8'd3:    seg7 = 7'b0110000;
         8'd4:    seg7 = 7'b0011001;
         8'd5:    seg7 = 7'b0010010;
         8'd6:    seg7 = 7'b0000010;
         8'd7:    seg7 = 7'b1111000;
         8'd8:    seg7 = 7'b0000000;
         8'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // gating with disable_clk makes the display visible the moment set mode ends
   assign blank    = disable_clk & blank_phase;
   assign v8       = 8'(value);
   assign tens8    = v8 / 8'd10;
   assign ones8    = v8 % 8'd10;
   assign led_tens = blank ? 7'b1111111 : seg7(tens8);
   assign led_ones = blank ? 7'b1111111 : seg7(ones8);

endmodule

// File: tb/tb_field_counter.sv
// Scoreboard bench for field_counter: seconds, chained hours and day instances.
module tb_field_counter;

   logic clk50;
   logic rst_sec, rst_oth;
   logic sec_dis, sec_adj, sec_up;
   logic hr_chain, hr_tick, hr_adj, hr_up, hr_tin;
   logic day_dis, day_adj, day_up;

   logic [6:0] sec_val;
   logic       sec_carry;
   logic [6:0] sec_lt, sec_lo;
   logic [4:0] hr_val;
   logic       hr_carry;
   logic [6:0] hr_lt, hr_lo;
   logic [4:0] day_val;
   logic       day_carry;
   logic [6:0] day_lt, day_lo;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      int         cyc;
      int         dut;
      int         val;
      bit         carry;
      logic [6:0] lt;
      logic [6:0] lo;
      string      name;
   } exp_t;

   exp_t sbq[$];

   initial clk50 = 1'b0;
   always #5 clk50 = ~clk50;

   always @(posedge clk50) cyc <= cyc + 1;

   assign hr_tin = hr_chain ? sec_carry : hr_tick;

   field_counter #(.MIN_VALUE(0), .MAX_VALUE(59), .W(7), .EXT_TICK(0),
                   .TICK_DIV(4), .BLINK_DIV(5)) u_sec (
      .clk50(clk50), .reset(rst_sec), .disable_clk(sec_dis), .tick_in(1'b0),
      .adj_n(sec_adj), .adj_up(sec_up), .value(sec_val), .carry_out(sec_carry),
      .led_tens(sec_lt), .led_ones(sec_lo));

   field_counter #(.MIN_VALUE(0), .MAX_VALUE(23), .W(5), .EXT_TICK(1),
                   .TICK_DIV(4), .BLINK_DIV(5)) u_hr (
      .clk50(clk50), .reset(rst_oth), .disable_clk(1'b0), .tick_in(hr_tin),
      .adj_n(hr_adj), .adj_up(hr_up), .value(hr_val), .carry_out(hr_carry),
      .led_tens(hr_lt), .led_ones(hr_lo));

   field_counter #(.MIN_VALUE(1), .MAX_VALUE(31), .W(5), .EXT_TICK(1),
                   .TICK_DIV(4), .BLINK_DIV(5)) u_day (
      .clk50(clk50), .reset(rst_oth), .disable_clk(day_dis), .tick_in(1'b0),
      .adj_n(day_adj), .adj_up(day_up), .value(day_val), .carry_out(day_carry),
      .led_tens(day_lt), .led_ones(day_lo));

   function automatic logic [6:0] seg(input int d);
      case (d)
         0:       seg = 7'b1000000;
         1:       seg = 7'b1111001;
         2:       seg = 7'b0100100;
         3:       seg = 7'b0110000;
         4:       seg = 7'b0011001;
         5:       seg = 7'b0010010;
         6:       seg = 7'b0000010;
         7:       seg = 7'b1111000;
         8:       seg = 7'b0000000;
         9:       seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   endfunction

   task automatic push(input int c, input int d, input string nm, input int v,
                       input bit cy, input bit bl);
      exp_t e;
      e.cyc   = c;
      e.dut   = d;
      e.name  = nm;
      e.val   = v;
      e.carry = cy;
      e.lt    = bl ? 7'b1111111 : seg(v / 10);
      e.lo    = bl ? 7'b1111111 : seg(v % 10);
      sbq.push_back(e);
   endtask

   task automatic check(input exp_t e);
      int         av;
      logic       ac;
      logic [6:0] alt, alo;
      case (e.dut)
         0:       begin av = int'(sec_val); ac = sec_carry; alt = sec_lt; alo = sec_lo; end
         1:       begin av = int'(hr_val);  ac = hr_carry;  alt = hr_lt;  alo = hr_lo;  end
         default: begin av = int'(day_val); ac = day_carry; alt = day_lt; alo = day_lo; end
      endcase
      n_tests++;
      if (av != e.val) begin
         n_fail++;
         $display("FAIL %s value @%0d: got %0d expected %0d", e.name, e.cyc, av, e.val);
      end
      n_tests++;
      if (ac !== e.carry) begin
         n_fail++;
         $display("FAIL %s carry @%0d: got %b expected %b", e.name, e.cyc, ac, e.carry);
      end
      n_tests++;
      if ({alt, alo} !== {e.lt, e.lo}) begin
         n_fail++;
         $display("FAIL %s leds @%0d: got %b_%b expected %b_%b", e.name, e.cyc, alt, alo, e.lt, e.lo);
      end
   endtask

   always @(negedge clk50) begin
      int i;
      i = 0;
      while (i < sbq.size()) begin
         if (sbq[i].cyc == cyc) begin
            check(sbq[i]);
            sbq.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk50);
         #2;
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   localparam int C1 = 281;

   initial begin
      rst_sec = 1'b0; rst_oth = 1'b0;
      sec_dis = 1'b0; sec_adj = 1'b1; sec_up = 1'b1;
      hr_chain = 1'b1; hr_tick = 1'b0; hr_adj = 1'b1; hr_up = 1'b0;
      day_dis = 1'b1; day_adj = 1'b1; day_up = 1'b0;

      push(1, 0, "reset_sec", 0, 1'b0, 1'b0);
      push(1, 1, "reset_hr",  0, 1'b0, 1'b0);
      push(1, 2, "reset_day", 1, 1'b0, 1'b0);

      // free run from reset release after edge 2: one step per 4 edges, wrap at step 60
      for (int n = 0; n <= 250; n++)
         push(2 + n, 0, "sec_run", (n / 4) % 60, n == 240, 1'b0);
      push(242, 1, "chain_pre", 0, 1'b0, 1'b0);
      push(243, 1, "chain_adv", 1, 1'b0, 1'b0);

      push(14, 2, "day_press_lat", 1,  1'b0, 1'b0);
      push(15, 2, "day_down_wrap", 31, 1'b0, 1'b0);
      push(18, 2, "day_blank",     31, 1'b0, 1'b1);
      push(22, 2, "day_held",      31, 1'b0, 1'b0);
      push(34, 2, "day_up_lat",    31, 1'b0, 1'b0);
      push(35, 2, "day_up_wrap",   1,  1'b0, 1'b0);

      push(266, 1, "hr_adj_down",  0,  1'b0, 1'b0);
      push(267, 1, "hr_adj_wrap",  23, 1'b0, 1'b0);
      push(272, 1, "hr_pre_tick",  23, 1'b0, 1'b0);
      push(273, 1, "hr_tick_wrap", 0,  1'b1, 1'b0);
      push(274, 1, "hr_carry_end", 0,  1'b0, 1'b0);

      push(279, 0, "sec_pre_rst",   9, 1'b0, 1'b0);
      push(280, 0, "sec_async_rst", 0, 1'b0, 1'b0);
      push(C1 + 40,  0, "sec_at10",       10, 1'b0, 1'b0);
      push(C1 + 43,  0, "sec_pre_coll",   10, 1'b0, 1'b0);
      push(C1 + 44,  0, "collision",      11, 1'b0, 1'b0);
      push(C1 + 47,  0, "post_coll",      11, 1'b0, 1'b0);
      push(C1 + 48,  0, "post_coll_tick", 12, 1'b0, 1'b0);
      push(C1 + 49,  0, "pre_press",      12, 1'b0, 1'b0);
      push(C1 + 50,  0, "press_mid",      13, 1'b0, 1'b0);
      push(C1 + 53,  0, "presc_cleared",  13, 1'b0, 1'b0);
      push(C1 + 54,  0, "tick_after_clr", 14, 1'b0, 1'b0);
      push(C1 + 57,  0, "pause_vis",      14, 1'b0, 1'b0);
      push(C1 + 60,  0, "pause_vis2",     14, 1'b0, 1'b0);
      push(C1 + 61,  0, "pause_blank",    14, 1'b0, 1'b1);
      push(C1 + 65,  0, "pause_blank2",   14, 1'b0, 1'b1);
      push(C1 + 66,  0, "pause_vis3",     14, 1'b0, 1'b0);
      push(C1 + 71,  0, "pause_blank3",   14, 1'b0, 1'b1);
      push(C1 + 90,  0, "pause_vis4",     14, 1'b0, 1'b0);
      push(C1 + 93,  0, "pause_blank4",   14, 1'b0, 1'b1);
      push(C1 + 94,  0, "resume_vis",     14, 1'b0, 1'b0);
      push(C1 + 95,  0, "resume_hold",    14, 1'b0, 1'b0);
      push(C1 + 96,  0, "resume_tick",    15, 1'b0, 1'b0);
      push(C1 + 184, 0, "sec_at37",       37, 1'b0, 1'b0);
      push(C1 + 185, 0, "mid_reset",      0,  1'b0, 1'b0);

      wait_until(2);
      rst_sec = 1'b1; rst_oth = 1'b1;

      wait_until(12);  day_adj = 1'b0;
      wait_until(22);  day_adj = 1'b1;
      wait_until(26);  day_up  = 1'b1;
      wait_until(32);  day_adj = 1'b0;
      wait_until(40);  day_adj = 1'b1;

      wait_until(252); hr_chain = 1'b0;
      wait_until(254); hr_adj = 1'b0;
      wait_until(258); hr_adj = 1'b1;
      wait_until(264); hr_adj = 1'b0;
      wait_until(268); hr_adj = 1'b1;
      wait_until(272); hr_tick = 1'b1;
      wait_until(273); hr_tick = 1'b0;

      wait_until(280); rst_sec = 1'b0;
      wait_until(C1);  rst_sec = 1'b1;
      wait_until(C1 + 41);  sec_adj = 1'b0;
      wait_until(C1 + 45);  sec_adj = 1'b1;
      wait_until(C1 + 47);  sec_adj = 1'b0;
      wait_until(C1 + 51);  sec_adj = 1'b1;
      wait_until(C1 + 56);  sec_dis = 1'b1;
      wait_until(C1 + 94);  sec_dis = 1'b0;
      wait_until(C1 + 185); rst_sec = 1'b0;
      wait_until(C1 + 187); rst_sec = 1'b1;
      wait_until(C1 + 195);

      foreach (sbq[i]) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s never checked: cycle %0d now %0d", sbq[i].name, sbq[i].cyc, cyc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
